rr_mux_select_ctrl: RTL and testbench

- Round-robin controller for the 16-bit 4:1 datapath mux.
- Arbitrates four requesters and drives the mux select `s` from a register.
- Captures the mux output `d` one cycle after `s` is set, then presents the word with its channel number on a valid/ready output.
- Sits around the mux: it is upstream for `s` and downstream for `d`.

---
 rtl/rr_mux_select_pkg.sv | 25 ++
 rtl/rr_mux_select_ctrl_pick.sv | 39 +++
 rtl/rr_mux_select_ctrl.sv | 151 +++++++++++++++
 tb/tb_rr_mux_select_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_select_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_select_pkg
// Shared types and constants for the round-robin 4:1 mux select controller.
//   state_e        : controller FSM states (IDLE, SEL, HOLD)
//   N_CH, SEL_W    : channel count and select width (fixed 4 / 2)
//   DEFAULT_WIDTH  : default data width of the mux channels
//   onehot4()      : 2-bit channel index to one-hot grant vector
// -----------------------------------------------------------------------------
package rr_mux_select_pkg;

   localparam int N_CH          = 4;
   localparam int SEL_W         = 2;
   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      HOLD = 2'd2
   } state_e;

   function automatic logic [N_CH-1:0] onehot4(input logic [SEL_W-1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_mux_select_ctrl_pick.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational rotating-priority picker for four requesters.
// The search starts at ptr and wraps ptr, ptr+1, ptr+2, ptr+3 (mod 4);
// the first set request bit found is the winner.
//   req    [3:0] in  : request vector
//   ptr    [1:0] in  : highest-priority channel for this pick
//   winner [1:0] out : chosen channel (0 when no request)
//   any          out : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick4
   import rr_mux_select_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] winner,
   output logic             any
);

   logic [SEL_W-1:0] idx;
   logic             found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < N_CH; i++) begin
         // 2-bit addition wraps naturally, giving the mod-4 search order.
         idx = ptr + SEL_W'(i);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/rr_mux_select_ctrl.sv
// -----------------------------------------------------------------------------
// rr_mux_select_ctrl
// Round-robin controller wrapped around a combinational 16-bit 4:1 mux.
// It picks one of four requesters, drives the mux select s from a register,
// captures the mux output d one cycle later and offers the word together
// with its channel number on a valid/ready output.
//
// Build option:
//   RR_MUX_SELECT_FIXED_PRIO_EN : when defined, the pointer is held at 0 and
//                                 channel 0 always has highest priority.
//                                 Undefined (default): round-robin rotation.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   req  [3:0] in   per-channel level request, held until its gnt pulse
//   s    [1:0] out  registered mux select
//   d    [W]   in   mux output, sampled only in SEL
//   gnt  [3:0] out  one-hot, one-cycle pulse in the first HOLD cycle
//   out_data   out  captured word
//   out_chan   out  channel index of out_data
//   out_valid  out  out_data/out_chan valid
//   out_ready  in   consumer accepts when out_valid && out_ready
//   dbg_state  out  current FSM state (rr_mux_select_pkg::state_e encoding)
//   dbg_ptr    out  current round-robin pointer
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both 1. Once raised, out_valid stays high and out_data /
// out_chan stay stable until that transfer; out_valid never depends
// combinationally on out_ready.
// -----------------------------------------------------------------------------
module rr_mux_select_ctrl
   import rr_mux_select_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  req,
   output logic [SEL_W-1:0] s,
   input  logic [WIDTH-1:0] d,
   output logic [N_CH-1:0]  gnt,
   output logic [WIDTH-1:0] out_data,
   output logic [SEL_W-1:0] out_chan,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       dbg_state,
   output logic [SEL_W-1:0] dbg_ptr
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_SEL  = SEL;
   localparam logic [1:0] ST_HOLD = HOLD;

   logic [1:0]       state_q,     state_d;
   logic [SEL_W-1:0] s_q,         s_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;
   logic [N_CH-1:0]  gnt_q,       gnt_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_chan_q,  out_chan_d;
   logic             out_valid_q, out_valid_d;

   logic [SEL_W-1:0] pick_ptr;
   logic [SEL_W-1:0] winner;
   logic             any_req;

`ifdef RR_MUX_SELECT_FIXED_PRIO_EN
   // Fixed priority: search always starts at channel 0.
   assign pick_ptr = '0;
`else
   assign pick_ptr = ptr_q;
`endif

   rr_pick4 u_pick (
      .req    (req),
      .ptr    (pick_ptr),
      .winner (winner),
      .any    (any_req)
   );

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      ptr_d       = ptr_q;
      gnt_d       = '0;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               s_d     = winner;
               state_d = ST_SEL;
            end
         end
         ST_SEL: begin
            // s has been stable for a full cycle, so d reflects channel s_q.
            // The grant is committed even if req[s_q] has dropped meanwhile.
            out_data_d  = d;
            out_chan_d  = s_q;
            out_valid_d = 1'b1;
            gnt_d       = onehot4(s_q);
`ifdef RR_MUX_SELECT_FIXED_PRIO_EN
            ptr_d       = '0;
`else
            ptr_d       = s_q + 2'd1;
`endif
            state_d     = ST_HOLD;
         end
         ST_HOLD: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         s_q         <= '0;
         ptr_q       <= '0;
         gnt_q       <= '0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign s         = s_q;
   assign gnt       = gnt_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;
   assign dbg_state = state_q;
   assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_rr_mux_select_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_select_ctrl
// Bench for rr_mux_select_ctrl paired with a behavioural 16-bit 4:1 mux.
// A transaction-level reference model steps once per clock; a scoreboard
// queue holds the words expected on the valid/ready output.
// -----------------------------------------------------------------------------
module tb_rr_mux_select_ctrl;

   localparam int W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [3:0]    req = '0;
   logic [1:0]    s;
   logic [W-1:0]  d;
   logic [3:0]    gnt;
   logic [W-1:0]  out_data;
   logic [1:0]    out_chan;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    dbg_state;
   logic [1:0]    dbg_ptr;

   logic [W-1:0]  a [4];

   // stand-in for the existing combinational 4:1 mux
   assign d = a[s];

   rr_mux_select_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .s         (s),
      .d         (d),
      .gnt       (gnt),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dbg_state (dbg_state),
      .dbg_ptr   (dbg_ptr)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // phase: 0 waiting for requests, 1 select applied, 2 word on output
   int          m_phase;
   int          m_ptr;
   int          m_s;
   int          m_gnt;
   int          m_valid;
   int          m_data;
   int          m_chan;

   logic [17:0] exp_q [$];    // {chan, data} in expected transfer order
   int          hs_chan [$];  // channels of observed transfers

   function automatic int pick(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return 0;
   endfunction

   task automatic model_step(input logic [3:0] r, input logic rdy, input logic rs);
      if (rs) begin
         m_phase = 0; m_ptr = 0; m_s = 0; m_gnt = 0;
         m_valid = 0; m_data = 0; m_chan = 0;
         exp_q.delete();
         return;
      end
      m_gnt = 0;
      if (m_phase == 0) begin
         if (r != 0) begin
`ifdef RR_MUX_SELECT_FIXED_PRIO_EN
            m_s = pick(r, 0);
`else
            m_s = pick(r, m_ptr);
`endif
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_data  = int'(a[m_s]);
         m_chan  = m_s;
         m_valid = 1;
         m_gnt   = 1 << m_s;
`ifndef RR_MUX_SELECT_FIXED_PRIO_EN
         m_ptr   = (m_s + 1) % 4;
`endif
         exp_q.push_back({2'(m_chan), 16'(m_data)});
         m_phase = 2;
      end else begin
         if (rdy) begin
            m_valid = 0;
            m_phase = 0;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic [3:0] r, input logic rdy, input logic rs);
      logic [17:0] e;
      req = r; out_ready = rdy; rst = rs;
      if (!rs && out_valid && rdy) begin
         if (exp_q.size() == 0) check_eq("sb_unexpected", 1, 0);
         else begin
            e = exp_q[0];
            check_eq("sb_word", {14'd0, out_chan, out_data}, {14'd0, e});
         end
         hs_chan.push_back(int'(out_chan));
      end
      model_step(r, rdy, rs);
      @(posedge clk);
      #1;
      check_eq("state",     32'(dbg_state), 32'(m_phase));
      check_eq("s",         32'(s),         32'(m_s));
      check_eq("gnt",       32'(gnt),       32'(m_gnt));
      check_eq("out_valid", 32'(out_valid), 32'(m_valid));
      check_eq("out_word",  {14'd0, out_chan, out_data}, {14'd0, 2'(m_chan), 16'(m_data)});
      check_eq("ptr",       32'(dbg_ptr),   32'(m_ptr));
   endtask

   // pop the scoreboard entry only after its handshake edge was driven
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] rq;
      for (int i = 0; i < 4; i++) a[i] = '0;

      // reset
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      check_eq("rst_valid", 32'(out_valid), 0);
      check_eq("rst_s",     32'(s),         0);

      // single request, known data
      a[0] = 16'b1101001101010101;
      step(4'b0001, 1'b1, 1'b0);
      check_eq("t1_s_c1", 32'(s), 0);
      step(4'b0001, 1'b1, 1'b0);
      check_eq("t1_valid_c2", 32'(out_valid), 1);
      check_eq("t1_data",     32'(out_data),  32'h0000D355);
      check_eq("t1_gnt",      32'(gnt),       32'b0001);
      step(4'b0000, 1'b1, 1'b0);
      check_eq("t1_gnt_off",  32'(gnt),       0);
      check_eq("t1_accepted", 32'(out_valid), 0);
      step(4'b0000, 1'b1, 1'b0);

      // all requesting, ready tied high: strict rotation 0,1,2,3,0
      step(4'b0000, 1'b0, 1'b1);
      a[0] = 16'h1111; a[1] = 16'h2222; a[2] = 16'h3333; a[3] = 16'h4444;
      hs_chan.delete();
      for (int i = 0; i < 15; i++) step(4'b1111, 1'b1, 1'b0);
      check_eq("rot_count", 32'(hs_chan.size()), 5);
      for (int i = 0; i < 5 && i < hs_chan.size(); i++)
         check_eq("rot_order", 32'(hs_chan[i]), 32'(i % 4));

      // consumer stalls for 5 cycles
      step(4'b0000, 1'b0, 1'b1);
      step(4'b0010, 1'b0, 1'b0);
      step(4'b0010, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(4'b0000, 1'b0, 1'b0);
         check_eq("stall_s",     32'(s),         1);
         check_eq("stall_chan",  32'(out_chan),  1);
         check_eq("stall_data",  32'(out_data),  32'h2222);
         check_eq("stall_valid", 32'(out_valid), 1);
      end
      step(4'b0000, 1'b1, 1'b0);
      check_eq("stall_release", 32'(out_valid), 0);

      // reset while holding a word
      step(4'b0001, 1'b0, 1'b0);
      step(4'b0001, 1'b0, 1'b0);
      check_eq("hold_valid", 32'(out_valid), 1);
      step(4'b0000, 1'b0, 1'b1);
      check_eq("rsthold_valid", 32'(out_valid), 0);
      check_eq("rsthold_s",     32'(s),         0);
      check_eq("rsthold_ptr",   32'(dbg_ptr),   0);
      check_eq("rsthold_gnt",   32'(gnt),       0);
      step(4'b1000, 1'b1, 1'b0);
      step(4'b1000, 1'b1, 1'b0);
      check_eq("ch3_gnt", 32'(gnt), 32'b1000);
      step(4'b0000, 1'b1, 1'b0);

      // ch2 granted last, then 0101: ch0 wins in both modes
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      check_eq("ch2_gnt", 32'(gnt), 32'b0100);
      step(4'b0000, 1'b1, 1'b0);
      step(4'b0101, 1'b1, 1'b0);
      step(4'b0101, 1'b1, 1'b0);
      check_eq("wrap_gnt", 32'(gnt), 32'b0001);
      step(4'b0000, 1'b1, 1'b0);

      // ch2 granted last, then 0110 held
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0000, 1'b1, 1'b0);
      hs_chan.delete();
      for (int i = 0; i < 9; i++) step(4'b0110, 1'b1, 1'b0);
      check_eq("p_count", 32'(hs_chan.size()), 3);
      if (hs_chan.size() == 3) begin
`ifdef RR_MUX_SELECT_FIXED_PRIO_EN
         check_eq("p_0", 32'(hs_chan[0]), 1);
         check_eq("p_1", 32'(hs_chan[1]), 1);
         check_eq("p_2", 32'(hs_chan[2]), 1);
`else
         check_eq("p_0", 32'(hs_chan[0]), 1);
         check_eq("p_1", 32'(hs_chan[1]), 2);
         check_eq("p_2", 32'(hs_chan[2]), 1);
`endif
      end

      // randomized traffic: requesters hold until granted, random ready/reset
      rq = '0;
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ((m_gnt >> c) & 1) rq[c] = 1'b0;
            else if ($urandom_range(3) == 0) rq[c] = 1'b1;
            a[c] = W'($urandom);
         end
         step(rq, ($urandom_range(2) != 0), ($urandom_range(49) == 0));
         if (rst) rq = '0;
      end
      step(4'b0000, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
